// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the serial subtractor.
// Optional add mode is enabled by defining SERIAL_SUBTRACTOR_ADD_MODE_EN.
package serial_sub_pkg;

    localparam int N_DEF = 32;
    localparam int W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Slice counter width; never narrower than one bit so W == N still has a counter.
    function automatic int cnt_width(input int slices);
        return (slices <= 1) ? 1 : $clog2(slices);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bundle for the serial subtractor.
// The op select exists only when SERIAL_SUBTRACTOR_ADD_MODE_EN is defined.
interface serial_subtractor_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    logic         op;
`endif
    logic         busy;
    logic         done;
    logic [N-1:0] Diff;
    logic         Borrow;
    logic         Ovf;

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    modport master (output start, A, B, op, input busy, done, Diff, Borrow, Ovf);
    modport slave  (input start, A, B, op, output busy, done, Diff, Borrow, Ovf);
`else
    modport master (output start, A, B, input busy, done, Diff, Borrow, Ovf);
    modport slave  (input start, A, B, output busy, done, Diff, Borrow, Ovf);
`endif

endinterface

// File: rtl/serial_subtractor_slice.sv
// Combinational W-bit ripple of full adders; also exposes the carry into the top bit
// so the caller can form signed overflow on the final slice.
module serial_sub_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cout     = c[W];
    assign c_msb_in = c[W-1];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle two's-complement subtractor: Diff = A + ~B + 1, W bits per cycle.
// Defining SERIAL_SUBTRACTOR_ADD_MODE_EN adds an op input (1 = add) sampled with start.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold last result
//   RUN   | one W-bit slice per cycle, LSB slice first
//   DONE  | publish Diff/Borrow/Ovf, pulse done, return to IDLE
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input logic                clk,
    input logic                rst,
    serial_subtractor_if.slave bus
);

    localparam int               SLICES = N / W;
    localparam int               CNT_W  = cnt_width(SLICES);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(SLICES - 1);

    state_t           state;
    logic [N-1:0]     a_reg;
    logic [N-1:0]     b_reg;
    logic [N-1:0]     res;
    logic [N-1:0]     res_next;
    logic             carry;
    logic             msb_cin;
    logic [CNT_W-1:0] cnt;
    logic             borrow_fin;

    logic [W-1:0]     sum;
    logic             cout;
    logic             c_msb;

    serial_sub_slice #(.W(W)) u_slice (
        .a        (a_reg[W-1:0]),
        .b        (b_reg[W-1:0]),
        .cin      (carry),
        .s        (sum),
        .cout     (cout),
        .c_msb_in (c_msb)
    );

    // Result fills from the top so the LSB slice ends up at bit 0 after the last slice.
    if (W == N) begin : g_one
        assign res_next = sum;
    end else begin : g_shift
        assign res_next = {sum, res[N-1:W]};
    end

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    logic op_add;
    assign borrow_fin = op_add ? carry : ~carry;
`else
    assign borrow_fin = ~carry;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            res        <= '0;
            carry      <= 1'b0;
            msb_cin    <= 1'b0;
            cnt        <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.Diff   <= '0;
            bus.Borrow <= 1'b0;
            bus.Ovf    <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
            op_add     <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg    <= bus.A;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
                        b_reg    <= bus.op ? bus.B : ~bus.B;
                        carry    <= ~bus.op;
                        op_add   <= bus.op;
`else
                        b_reg    <= ~bus.B;
                        carry    <= 1'b1;
`endif
                        cnt      <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    res     <= res_next;
                    a_reg   <= a_reg >> W;
                    b_reg   <= b_reg >> W;
                    carry   <= cout;
                    msb_cin <= c_msb;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        bus.busy <= 1'b0;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.done   <= 1'b1;
                    bus.Diff   <= res;
                    bus.Borrow <= borrow_fin;
                    bus.Ovf    <= carry ^ msb_cin;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at W=4, W=1 and W=32 sharing one stimulus bus.
module tb_serial_subtractor;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] a_in = '0;
    logic [N-1:0] b_in = '0;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    logic         op = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    int wv[3]     = '{4, 1, 32};
    int slices[3] = '{8, 32, 1};

    logic         busy_v[3];
    logic         done_v[3];
    logic [N-1:0] diff_v[3];
    logic         borrow_v[3];
    logic         ovf_v[3];

    always #5 clk = ~clk;

    serial_subtractor_if #(.N(N)) bus4  ();
    serial_subtractor_if #(.N(N)) bus1  ();
    serial_subtractor_if #(.N(N)) bus32 ();

    assign bus4.start  = start;  assign bus4.A  = a_in; assign bus4.B  = b_in;
    assign bus1.start  = start;  assign bus1.A  = a_in; assign bus1.B  = b_in;
    assign bus32.start = start;  assign bus32.A = a_in; assign bus32.B = b_in;
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    assign bus4.op = op; assign bus1.op = op; assign bus32.op = op;
`endif

    assign busy_v[0] = bus4.busy;   assign done_v[0] = bus4.done;   assign diff_v[0] = bus4.Diff;
    assign borrow_v[0] = bus4.Borrow;   assign ovf_v[0] = bus4.Ovf;
    assign busy_v[1] = bus1.busy;   assign done_v[1] = bus1.done;   assign diff_v[1] = bus1.Diff;
    assign borrow_v[1] = bus1.Borrow;   assign ovf_v[1] = bus1.Ovf;
    assign busy_v[2] = bus32.busy;  assign done_v[2] = bus32.done;  assign diff_v[2] = bus32.Diff;
    assign borrow_v[2] = bus32.Borrow;  assign ovf_v[2] = bus32.Ovf;

    serial_subtractor #(.N(N), .W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
    serial_subtractor #(.N(N), .W(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
    serial_subtractor #(.N(N), .W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset(input int k);
        rst = 1'b1;
        start = 1'b0;
        step();
        step();
        rst = 1'b0;
        n_vec++;
        if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0 || diff_v[k] !== '0 ||
            borrow_v[k] !== 1'b0 || ovf_v[k] !== 1'b0) begin
            n_err++;
            $display("FAIL reset W=%0d: busy=%b done=%b Diff=%h Borrow=%b Ovf=%b, required all zero",
                     wv[k], busy_v[k], done_v[k], diff_v[k], borrow_v[k], ovf_v[k]);
        end
    endtask

    // One full operation from IDLE with cycle-exact busy/done checks.
    task automatic test_op(input int k, input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N-1:0] ed, input logic eb, input logic eo);
        start = 1'b1;
        a_in = a;
        b_in = b;
        step();
        start = 1'b0;
        a_in = ~a;
        b_in = a ^ b;
        for (int i = 0; i < slices[k]; i++) begin
            n_vec++;
            if (busy_v[k] !== 1'b1 || done_v[k] !== 1'b0) begin
                n_err++;
                $display("FAIL %s busy W=%0d cycle %0d: busy=%b done=%b, required busy=1 done=0",
                         name, wv[k], i, busy_v[k], done_v[k]);
            end
            step();
        end
        n_vec++;
        if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_state W=%0d: busy=%b done=%b, required 0 0", name, wv[k], busy_v[k], done_v[k]);
        end
        step();
        n_vec++;
        if (done_v[k] !== 1'b1 || diff_v[k] !== ed || borrow_v[k] !== eb || ovf_v[k] !== eo) begin
            n_err++;
            $display("FAIL %s result W=%0d: done=%b Diff=%h Borrow=%b Ovf=%b, required 1 %h %b %b",
                     name, wv[k], done_v[k], diff_v[k], borrow_v[k], ovf_v[k], ed, eb, eo);
        end
        step();
        n_vec++;
        if (done_v[k] !== 1'b0 || diff_v[k] !== ed) begin
            n_err++;
            $display("FAIL %s hold W=%0d: done=%b Diff=%h, required 0 %h", name, wv[k], done_v[k], diff_v[k], ed);
        end
    endtask

    task automatic test_arith(input int k);
        test_op(k, "5-3", 32'd5, 32'd3, 32'h0000_0002, 1'b0, 1'b0);
        test_op(k, "3-5", 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0);
        test_op(k, "min-1", 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        test_op(k, "max-m1", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
        test_op(k, "eq", 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0);
        test_op(k, "0-min", 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    endtask

    // start during RUN is ignored and operand changes after acceptance have no effect.
    task automatic test_ignore_busy(input int k);
        int e;
        start = 1'b1; a_in = 32'd10; b_in = 32'd4;
        step();
        start = 1'b0;
        step();
        start = 1'b1; a_in = 32'd1; b_in = 32'd1;
        step();
        start = 1'b0; a_in = 32'hDEAD_BEEF; b_in = 32'h0BAD_F00D;
        e = 2;
        while (e < slices[k] + 1) begin
            n_vec++;
            if (done_v[k] !== 1'b0) begin
                n_err++;
                $display("FAIL ignore early_done W=%0d edge %0d: done=%b, required 0", wv[k], e, done_v[k]);
            end
            step();
            e++;
        end
        n_vec++;
        if (done_v[k] !== 1'b1 || diff_v[k] !== 32'd6) begin
            n_err++;
            $display("FAIL ignore result W=%0d: done=%b Diff=%h, required 1 00000006", wv[k], done_v[k], diff_v[k]);
        end
        for (int i = 0; i < slices[k] + 3; i++) begin
            step();
            n_vec++;
            if (done_v[k] !== 1'b0 || busy_v[k] !== 1'b0) begin
                n_err++;
                $display("FAIL ignore extra W=%0d: done=%b busy=%b, required 0 0", wv[k], done_v[k], busy_v[k]);
            end
        end
    endtask

    task automatic test_back_to_back(input int k);
        start = 1'b1; a_in = 32'd7; b_in = 32'd2;
        step();
        start = 1'b0;
        for (int i = 0; i < slices[k]; i++) step();
        // DONE state: this start must be dropped, the next edge (IDLE) takes it.
        start = 1'b1; a_in = 32'd100; b_in = 32'd1;
        step();
        n_vec++;
        if (done_v[k] !== 1'b1 || diff_v[k] !== 32'd5 || busy_v[k] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b first W=%0d: done=%b Diff=%h busy=%b, required 1 00000005 0",
                     wv[k], done_v[k], diff_v[k], busy_v[k]);
        end
        step();
        start = 1'b0;
        n_vec++;
        if (busy_v[k] !== 1'b1) begin
            n_err++;
            $display("FAIL b2b accept W=%0d: busy=%b, required 1", wv[k], busy_v[k]);
        end
        for (int i = 0; i < slices[k]; i++) step();
        step();
        n_vec++;
        if (done_v[k] !== 1'b1 || diff_v[k] !== 32'd99) begin
            n_err++;
            $display("FAIL b2b second W=%0d: done=%b Diff=%h, required 1 00000063", wv[k], done_v[k], diff_v[k]);
        end
        step();
    endtask

    task automatic test_abort(input int k);
        int pre;
        test_op(k, "pre_abort", 32'd20, 32'd1, 32'd19, 1'b0, 1'b0);
        pre = (slices[k] > 4) ? 3 : slices[k] - 1;
        start = 1'b1; a_in = 32'd50; b_in = 32'd60;
        step();
        start = 1'b0;
        for (int i = 0; i < pre; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if (busy_v[k] !== 1'b0 || done_v[k] !== 1'b0 || diff_v[k] !== '0 ||
            borrow_v[k] !== 1'b0 || ovf_v[k] !== 1'b0) begin
            n_err++;
            $display("FAIL abort W=%0d: busy=%b done=%b Diff=%h Borrow=%b Ovf=%b, required all zero",
                     wv[k], busy_v[k], done_v[k], diff_v[k], borrow_v[k], ovf_v[k]);
        end
        for (int i = 0; i < slices[k] + 3; i++) begin
            step();
            n_vec++;
            if (done_v[k] !== 1'b0 || busy_v[k] !== 1'b0) begin
                n_err++;
                $display("FAIL abort ghost W=%0d: done=%b busy=%b, required 0 0", wv[k], done_v[k], busy_v[k]);
            end
        end
        test_op(k, "post_abort", 32'd9, 32'd3, 32'd6, 1'b0, 1'b0);
    endtask

`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
    task automatic test_add_mode(input int k);
        op = 1'b1;
        test_op(k, "add5+3", 32'd5, 32'd3, 32'd8, 1'b0, 1'b0);
        test_op(k, "add_ovf", 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
        test_op(k, "add_carry", 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1, 1'b0);
        op = 1'b0;
        test_op(k, "sub_after_add", 32'd5, 32'd3, 32'd2, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        for (int k = 0; k < 3; k++) begin
            test_reset(k);
            test_arith(k);
            test_ignore_busy(k);
            test_back_to_back(k);
            test_abort(k);
`ifdef SERIAL_SUBTRACTOR_ADD_MODE_EN
            test_add_mode(k);
`endif
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle signed two's-complement subtractor for the CPU datapath.
- Computes DIFF = A - B as A + ~B + 1, processing W bits per cycle through a carry register.
- Lower-area counterpart to the team's combinational ripple-carry adder. Used by non-critical units (compare, divider pre-step).
- Uses a start/busy/done handshake. Reports unsigned borrow and signed overflow.

Parameters:
- N, 32, operand and result width in bits. Must satisfy N % W == 0.
- W, 4, bits processed per cycle. Range 1..N.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- A  input  N  minuend, signed two's complement.
- B  input  N  subtrahend, signed two's complement.
- busy  output  1  high while an operation is in progress (RUN).
- done  output  1  one-cycle pulse; result valid.
- Diff  output  N  A - B modulo 2^N.
- Borrow  output  1  1 when unsigned A < B, i.e. NOT final carry-out.
- Ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, Diff=0, Borrow=0, Ovf=0; slice counter=0; carry register=0.
- States:
  - IDLE: on start=1, capture A and ~B into shift registers, set carry=1, counter=0, go to RUN.
  - RUN:
    - Each cycle, add the low W bits of the A register, the ~B register, and carry.
    - Shift the W-bit sum into the top of the result register (LSB slice first).
    - Shift both operand registers right by W.
    - Update carry; increment counter.
    - After slice N/W-1, go to DONE.
  - DONE:
    - done=1 for exactly one cycle.
    - Load Diff, Borrow, Ovf from internal registers.
    - Go to IDLE.
- Latency: start sampled at edge t. busy=1 from t+1 through t+N/W. done=1 and outputs valid in the cycle after edge t+N/W+1. For the defaults: 8 RUN cycles; done visible 9 edges after start.
- Outputs:
  - Diff, Borrow and Ovf are driven only from DONE.
  - They hold their values until the next DONE; they are not cleared by start.
- Overflow computation: the final slice exposes the carry into bit N-1 and the carry out of bit N-1. Ovf = XOR of the two. Borrow = ~carry_out.
- start while busy or done: ignored, no queuing. Operands captured at acceptance are unaffected by later A/B changes.
- Back-to-back: start asserted in the DONE cycle is ignored. It is accepted in the following IDLE cycle, so the minimum issue interval is N/W+2 cycles.
- rst mid-operation: abort immediately to reset values. No done pulse for the aborted operation.
- Case W == N: a single RUN cycle; the behaviour is otherwise identical.

Optional Feature:
- Macro SERIAL_SUBTRACTOR_ADD_MODE_EN.
- When defined:
  - Extra input port op (1 bit), sampled with start. op=0 selects subtract.
  - op=1 selects add: B is captured uninverted, initial carry=0, and Borrow reports the unsigned carry-out directly.
  - Ovf uses the same XOR rule.
- When undefined: no op port; the block always subtracts.

Decomposition:
- Package serial_sub_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Function clog2-based counter width CNT_W = clog2(N/W), minimum 1.
  - Default constants N_DEF=32, W_DEF=4.
- Sub-module serial_sub_slice: a combinational W-bit ripple of full adders.
  - Inputs: a[W], b[W], cin.
  - Outputs: s[W], cout, c_msb_in (carry into bit W-1).
  - Instantiated once in the top module.

Test Plan:
- A=5, B=3 with start pulse -> done 9 edges later; Diff=0x00000002, Borrow=0, Ovf=0; busy high for 8 cycles.
- A=3, B=5 -> Diff=0xFFFFFFFE, Borrow=1, Ovf=0.
- A=0x80000000, B=1 -> Diff=0x7FFFFFFF, Borrow=0, Ovf=1.
- A=0x7FFFFFFF, B=0xFFFFFFFF -> Diff=0x80000000, Borrow=1, Ovf=1.
- Start with A=10, B=4; at RUN cycle 2, pulse start with A=1, B=1 and change A/B -> single done, Diff=6. Issue another start in the DONE cycle -> ignored; the next IDLE start is accepted.
- Start, then rst at RUN cycle 4 -> next cycle busy=0, done=0, Diff=0, Borrow=0, Ovf=0, and no done pulse follows. A new start then completes correctly. Repeat the whole suite with W=1 (32 RUN cycles) and W=32 (1 RUN cycle).
